rv32i_dmem_responder: RTL
=========================

Name: rv32i_dmem_responder

Overview:
- Data-memory responder for the RV32i pipelined core's dmem port: accepts read/write requests with byte-lane enables and answers after a parameterised wait, asserting a valid strobe.
- The core raises the request and holds it stable, stalling its exec stage while request is high and valid is low.
- The block is the slave end of that handshake.
- Storage is an internal word-addressed byte-lane RAM.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two.
- LATENCY, 2: cycles from request acceptance to valid_o; legal range 1..15.
- BASE_ADDR, 32'h0000_2000: byte address of word 0.

Ports:
- clk_i  in  1: clock, rising edge.
- reset_i  in  1: synchronous, active-high reset.
- dmem_add_i  in  32: byte address from core.
- dmem_di_i  in  32: write data.
- dmem_we_i  in  1: write request.
- dmem_re_i  in  1: read request.
- dmem_ble_i  in  4: byte-lane enables; bit n covers bits 8n+7:8n.
- dmem_do_o  out  32: read data.
- dmem_valid_o  out  1: response strobe; high for exactly one cycle per accepted request.
- dmem_err_o  out  1: out-of-range flag, qualified by dmem_valid_o.

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous, active-high.
- Reset values: state IDLE, wait counter 0, dmem_valid_o 0, dmem_do_o 0, dmem_err_o 0. RAM contents are not cleared.
- Reset asserted mid-WAIT or mid-RESP: the request is abandoned and no write commits.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if (we_i | re_i) at an edge, latch add, di, ble and we into request registers; load counter with LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: decrement counter each cycle; go to RESP when the counter reaches 1. If we_i and re_i are both low at an edge, the request is aborted (core flush): return to IDLE, no write, no valid.
  - RESP: dmem_valid_o=1, driven from the registered state. At the RESP edge:
    - a write commits the lanes selected by the latched ble into RAM;
    - the next state is always IDLE, so back-to-back requests cost LATENCY+1 cycles each.
- Latency: request first seen at edge t gives dmem_valid_o high in cycle t+LATENCY.
- Read data:
  - dmem_do_o is loaded from RAM[latched word index] on the edge entering RESP, so it is valid while dmem_valid_o is high.
  - It holds its value otherwise.
  - Lanes are not masked; the core performs extension and shifting.
- we_i and re_i both high: treated as a write. dmem_do_o returns the pre-write word (read-before-write).
- Address decode:
  - word index = (add - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
  - Address bits [1:0] are ignored.
  - If add < BASE_ADDR or add >= BASE_ADDR + 4*DEPTH_WORDS, the request is out of range: no write, dmem_do_o = 0, dmem_err_o = 1 during RESP.
- ble = 4'b0000 with we: completes normally with no RAM change.
- Input changes during WAIT: ignored, except the abort rule above.

Optional Feature:
- Macro: DMEM_RANDOM_LATENCY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances every cycle.
  - The counter loads with LATENCY-1 + lfsr[1:0], so latency is LATENCY..LATENCY+3.
  - Used to stress core stall logic.
- Undefined: latency is exactly LATENCY and no LFSR logic exists.

Decomposition:
- RV32i_pkg:
  - typedef enum logic [1:0] dmem_state_t {DMEM_IDLE, DMEM_WAIT, DMEM_RESP}.
  - localparam DMEM_LFSR_SEED = 8'hA5.
- Sub-module dmem_byte_ram:
  - synchronous read;
  - per-lane write enables;
  - read-before-write on the same edge;
  - parameter DEPTH_WORDS.
- The FSM, decode and optional LFSR stay in rv32i_dmem_responder.

Test Plan:
- Full-word write, LATENCY=2, macro off: write add=BASE_ADDR+8, di=32'hDEADBEEF, ble=4'hF held until valid; then read the same address -> each valid_o exactly 2 cycles after request, do_o=32'hDEADBEEF, err=0.
- Lane merge: word initialised to 32'h11223344, then write ble=4'b0101, di=32'hAABBCCDD -> read returns 32'h11BB33DD.
- Abort: read request is dropped one cycle after acceptance with LATENCY=3 -> no valid_o pulse, state IDLE; a new read then completes 3 cycles later.
- Out of range: write to BASE_ADDR-4, then read BASE_ADDR+4*DEPTH_WORDS -> valid_o with err_o=1 and do_o=0; word 0 and the last word are unchanged.
- Reset during WAIT of a write -> valid_o stays 0, target word unchanged, do_o=0.
- Macro on: 200 random back-to-back requests -> every latency is in [LATENCY, LATENCY+3], valid_o is exactly one cycle per request, and data matches a reference model.

Source files
------------

// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared types and constants for the RV32i data-memory responder.
//   dmem_state_t   : responder FSM states
//   dmem_req_t     : request fields latched when a request is accepted
//   DMEM_LFSR_SEED : reset value of the optional latency-jitter LFSR
//   lfsr8_next     : one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package rv32i_dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    localparam int          DMEM_LANES     = 4;
    localparam int          DMEM_LANE_W    = 8;
    localparam logic [7:0]  DMEM_LFSR_SEED = 8'hA5;

    typedef struct packed {
        logic [31:0]           add;
        logic [31:0]           di;
        logic [DMEM_LANES-1:0] ble;
        logic                  we;
    } dmem_req_t;

    // Shift left, feedback from taps 8,6,5,4 (bits 7,5,4,3) into bit 0.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/rv32i_dmem_responder_byte_ram.sv
// Word-addressed RAM built from independent byte lanes.
//   clk_i      : clock, rising edge
//   rd_en_i    : load rd_data_o from rd_idx_i on this edge (else hold)
//   rd_idx_i   : read word index
//   rd_data_o  : registered read data
//   wr_be_i    : per-lane write enables
//   wr_idx_i   : write word index
//   wr_data_i  : write data
// A read and write to the same word on the same edge returns the old word.
module dmem_byte_ram
    import rv32i_dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rd_en_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [31:0]           rd_data_o,
    input  logic [DMEM_LANES-1:0] wr_be_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [31:0]           wr_data_i
);

    for (genvar l = 0; l < DMEM_LANES; l++) begin : g_lane
        logic [DMEM_LANE_W-1:0] mem [DEPTH_WORDS];

        always_ff @(posedge clk_i) begin
            if (wr_be_i[l])
                mem[wr_idx_i] <= wr_data_i[l*DMEM_LANE_W +: DMEM_LANE_W];
            if (rd_en_i)
                rd_data_o[l*DMEM_LANE_W +: DMEM_LANE_W] <= mem[rd_idx_i];
        end
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the RV32i core dmem port. Accepts a read or
// write, answers after LATENCY cycles with a one-cycle dmem_valid_o strobe.
//   clk_i, reset_i : clock and synchronous active-high reset
//   dmem_add_i     : byte address (bits [1:0] ignored)
//   dmem_di_i      : write data
//   dmem_we_i      : write request (wins when dmem_re_i is also high)
//   dmem_re_i      : read request
//   dmem_ble_i     : byte-lane enables for writes
//   dmem_do_o      : read data, valid with dmem_valid_o (pre-write word on writes)
//   dmem_valid_o   : response strobe
//   dmem_err_o     : out-of-range flag, qualified by dmem_valid_o
// Optional macro DMEM_RANDOM_LATENCY_EN: adds 0..3 cycles of pseudo-random
// latency from an 8-bit LFSR to exercise the core's stall logic.
module rv32i_dmem_responder
    import rv32i_dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] dmem_add_i,
    input  logic [31:0] dmem_di_i,
    input  logic        dmem_we_i,
    input  logic        dmem_re_i,
    input  logic [3:0]  dmem_ble_i,
    output logic [31:0] dmem_do_o,
    output logic        dmem_valid_o,
    output logic        dmem_err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 5;   // holds LATENCY-1+3 for LATENCY up to 15

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_load;
    dmem_req_t         req_q;
    logic              err_q;
    logic              do_zero_q;   // forces dmem_do_o to 0 after reset / out-of-range
    logic              req_any;

    logic [31:0]       cur_add;
    logic [32:0]       add_ext, lo_ext, hi_ext;
    logic              cur_in_range;
    logic [IDX_W-1:0]  cur_idx;
    logic              enter_resp;

    logic              ram_rd_en;
    logic [31:0]       ram_rd_data;
    logic [3:0]        ram_wr_be;

    assign req_any = dmem_we_i | dmem_re_i;

`ifdef DMEM_RANDOM_LATENCY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) lfsr_q <= DMEM_LFSR_SEED;
        else         lfsr_q <= lfsr8_next(lfsr_q);
    end

    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    // The address being decoded: live input while accepting in IDLE (the
    // LATENCY==1 case enters RESP straight from IDLE), latched otherwise.
    assign cur_add      = (state_q == DMEM_IDLE) ? dmem_add_i : req_q.add;
    assign add_ext      = {1'b0, cur_add};
    assign lo_ext       = {1'b0, BASE_ADDR};
    // 33-bit compare so a window ending at 4 GiB does not wrap
    assign hi_ext       = lo_ext + 33'(4 * DEPTH_WORDS);
    assign cur_in_range = (add_ext >= lo_ext) && (add_ext < hi_ext);
    assign cur_idx      = IDX_W'((cur_add - BASE_ADDR) >> 2);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMEM_IDLE: begin
                if (req_any) begin
                    cnt_d   = cnt_load;
                    state_d = (cnt_load == '0) ? DMEM_RESP : DMEM_WAIT;
                end
            end
            DMEM_WAIT: begin
                if (!req_any) begin
                    // core flushed the access
                    state_d = DMEM_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_d = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                state_d = DMEM_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = DMEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign enter_resp = (state_d == DMEM_RESP) && (state_q != DMEM_RESP);

    // Request capture; contents only matter while a request is in flight.
    always_ff @(posedge clk_i) begin
        if (state_q == DMEM_IDLE && req_any) begin
            req_q.add <= dmem_add_i;
            req_q.di  <= dmem_di_i;
            req_q.ble <= dmem_ble_i;
            req_q.we  <= dmem_we_i;
        end
    end

    // Response flags loaded together with the RAM read on entry to RESP.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q     <= 1'b0;
            do_zero_q <= 1'b1;
        end else if (enter_resp) begin
            err_q     <= !cur_in_range;
            do_zero_q <= !cur_in_range;
        end
    end

    // RAM read on the edge entering RESP; write commits on the RESP edge,
    // both suppressed by reset so an abandoned request leaves no trace.
    assign ram_rd_en = enter_resp && cur_in_range && !reset_i;
    assign ram_wr_be = (state_q == DMEM_RESP && req_q.we && cur_in_range && !reset_i)
                       ? req_q.ble : 4'b0000;

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk_i     (clk_i),
        .rd_en_i   (ram_rd_en),
        .rd_idx_i  (cur_idx),
        .rd_data_o (ram_rd_data),
        .wr_be_i   (ram_wr_be),
        .wr_idx_i  (cur_idx),
        .wr_data_i (req_q.di)
    );

    // ---------------- outputs ----------------
    always_comb begin
        dmem_valid_o = (state_q == DMEM_RESP);
        dmem_err_o   = (state_q == DMEM_RESP) && err_q;
        dmem_do_o    = do_zero_q ? 32'h0 : ram_rd_data;
    end

endmodule
